cpu_sequencer: RTL

- Multi-cycle fetch/execute controller for the 8-bit core; the initiator side of the ALU command interface.
- Fetches 9-bit instructions over a req/valid handshake, decodes them into ALU command fields and register-file addresses/write strobes, and sequences data-memory accesses.
- Holds the shift-carry register and the PC, consumes the ALU branch flags, and counts retired instructions.

---
 rtl/cpu_sequencer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/cpu_sequencer.sv
// Fetch/execute controller for the 8-bit core: fetches 9-bit instructions, drives
// ALU command fields and register-file strobes, sequences data-memory accesses.
//
// state   | meaning
// IDLE    | waiting for start after reset
// FETCH   | imem_req high, waiting for imem_valid
// EXEC    | decode/execute instr_reg, branch compare
// EXEC2   | taken branch: read R7 on port B, load pc
// MEM     | dmem_req high, waiting for dmem_done
// HALT    | halt executed, done high until start
module cpu_sequencer #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             done,
  output logic [PC_W-1:0]  pc,
  output logic             imem_req,
  input  logic             imem_valid,
  input  logic [8:0]       imem_data,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_done,
  output logic [2:0]       alu_cmd,
  output logic [2:0]       typeselect,
  output logic [3:0]       immed,
  output logic             sc_in,
  input  logic             sc_o,
  input  logic             notequal,
  input  logic             lessthan,
  output logic [2:0]       rf_ra_addr,
  output logic [2:0]       rf_rb_addr,
  input  logic [7:0]       rf_rb_data,
  output logic [2:0]       rf_wr_addr,
  output logic             rf_wr_en,
  output logic             rf_wr_sel,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EXEC, S_EXEC2, S_MEM, S_HALT
  } state_t;

  state_t     state;
  logic [8:0] instr_reg;
  logic       carry;
  logic [2:0] op;
  logic       is_halt;
  logic       taken;
  logic       active;

  assign op       = instr_reg[8:6];
  assign is_halt  = (instr_reg == 9'h1FF);
  assign taken    = ((op == 3'b011) && notequal) || ((op == 3'b110) && lessthan);
  assign active   = (state == S_EXEC) || (state == S_EXEC2) || (state == S_MEM);
  assign imem_req = (state == S_FETCH);
  assign dmem_req = (state == S_MEM);
  assign dmem_we  = (state == S_MEM) && instr_reg[5];
  assign done     = (state == S_HALT);
  assign sc_in    = carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= '0;
      carry     <= 1'b0;
      retired   <= '0;
      instr_reg <= '0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            state   <= S_FETCH;
            pc      <= '0;
            retired <= '0;
            carry   <= 1'b0;
          end
        end
        S_FETCH: begin
          if (imem_valid) begin
            instr_reg <= imem_data;
            state     <= S_EXEC;
          end
        end
        S_EXEC: begin
          // inc/dec (typeselect 110/111) do not touch the carry register
          if ((op == 3'b001) && (instr_reg[5:3] < 3'd6)) carry <= sc_o;
          if (op == 3'b010) begin
            state <= S_MEM;
          end else if (taken) begin
            state <= S_EXEC2;
          end else if (is_halt) begin
            state <= S_HALT;
          end else begin
            state <= S_FETCH;
            pc    <= pc + PC_W'(1);
            if (retired != {CNT_W{1'b1}}) retired <= retired + CNT_W'(1);
          end
        end
        S_EXEC2: begin
          state <= S_FETCH;
          pc    <= PC_W'(rf_rb_data);
          if (retired != {CNT_W{1'b1}}) retired <= retired + CNT_W'(1);
        end
        S_MEM: begin
          if (dmem_done) begin
            state <= S_FETCH;
            pc    <= pc + PC_W'(1);
            if (retired != {CNT_W{1'b1}}) retired <= retired + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    alu_cmd    = 3'b111;
    typeselect = 3'b000;
    immed      = 4'h0;
    rf_ra_addr = 3'd0;
    rf_rb_addr = 3'd0;
    rf_wr_addr = 3'd0;
    rf_wr_en   = 1'b0;
    rf_wr_sel  = 1'b0;
    if (active) begin
      alu_cmd = op;
      case (op)
        3'b000: begin
          rf_ra_addr = instr_reg[2:0];
          rf_wr_addr = instr_reg[5:3];
          rf_wr_en   = (state == S_EXEC);
        end
        3'b001: begin
          typeselect = instr_reg[5:3];
          rf_ra_addr = instr_reg[2:0];
          rf_wr_addr = instr_reg[2:0];
          rf_wr_en   = (state == S_EXEC);
        end
        3'b010: begin
          rf_rb_addr = instr_reg[2:0];
          rf_wr_addr = instr_reg[2:0];
          // load data is written back on the completion cycle itself
          if ((state == S_MEM) && dmem_done && !instr_reg[5]) begin
            rf_wr_en  = 1'b1;
            rf_wr_sel = 1'b1;
          end
        end
        3'b011, 3'b110: begin
          rf_ra_addr = instr_reg[5:3];
          rf_rb_addr = (state == S_EXEC2) ? 3'd7 : instr_reg[2:0];
        end
        3'b100: begin
          immed    = instr_reg[3:0];
          rf_wr_en = (state == S_EXEC);
        end
        3'b101: begin
          rf_ra_addr = instr_reg[5:3];
          rf_rb_addr = instr_reg[2:0];
          rf_wr_addr = instr_reg[5:3];
          rf_wr_en   = (state == S_EXEC);
        end
        default: ;
      endcase
    end
  end

endmodule
